// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the period of a slow tick waveform in clk cycles
// and decodes it into speed = floor(MAX_SPEED / period) with a sequential
// restoring divider (one quotient bit per cycle, no combinational divide).
module tick_period_meter #(
  parameter int unsigned MAX_SPEED      = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  output logic [25:0] speed_out,
  output logic        speed_valid,
  output logic [25:0] period_out,
  output logic        stalled,
  output logic        overrun
);

  localparam int unsigned    QW          = 26;
  localparam logic [31:0]    DIVIDEND    = 32'(MAX_SPEED);
  localparam logic [QW-1:0]  DVD_HI      = QW'(DIVIDEND >> QW);
  localparam logic [QW-1:0]  DVD_LO      = DIVIDEND[QW-1:0];
  localparam logic [QW-1:0]  TIMEOUT_CNT = QW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t        state;
  logic          tick_s1, tick_s2, tick_prev;
  logic          tick_edge;
  logic [QW-1:0] cnt;
  logic          timeout_hit;
  logic          div_start;

  logic          div_busy;
  logic [4:0]    div_step;
  logic          div_sat;
  logic [QW-1:0] div_divisor;
  logic [QW-1:0] div_rem;
  logic [QW-1:0] div_lo;
  logic [QW-2:0] div_quot;
  logic [QW:0]   rem_shift;
  logic [QW:0]   rem_diff;
  logic          rem_ge;
  logic [QW-1:0] rem_next;

  // Two-flop synchronizer plus previous-value register for rise detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      tick_s1   <= tick_in;
      tick_s2   <= tick_s1;
      tick_prev <= tick_s2;
    end
  end

  // Rising-edge, timeout and divider-start decode
  always_comb begin
    tick_edge   = tick_s2 & ~tick_prev;
    timeout_hit = (state == MEASURE) && !tick_edge && (cnt == TIMEOUT_CNT);
    div_start   = (state == MEASURE) && tick_edge && !div_busy;
  end

  // Measurement FSM: arms on the first edge, captures the period on later edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period_out <= '0;
      overrun    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick_edge) begin
            cnt   <= QW'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (tick_edge) begin
            period_out <= cnt;
            cnt        <= QW'(1);
            if (div_busy) overrun <= 1'b1;
          end else if (timeout_hit) begin
            state      <= IDLE;
            cnt        <= '0;
            period_out <= '0;
          end else begin
            cnt <= cnt + QW'(1);
          end
        end
      endcase
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift = {div_rem, div_lo[QW-1]};
    rem_diff  = rem_shift - {1'b0, div_divisor};
    rem_ge    = ~rem_diff[QW];
    rem_next  = rem_ge ? rem_diff[QW-1:0] : rem_shift[QW-1:0];
  end

  // Divider sequencing and speed output; a timeout aborts any division in flight.
  // Saturation is decided up front: the quotient overflows 26 bits exactly when
  // the dividend bits above bit 25 are already >= the divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy    <= 1'b0;
      div_step    <= '0;
      div_sat     <= 1'b0;
      div_divisor <= '0;
      div_rem     <= '0;
      div_lo      <= '0;
      div_quot    <= '0;
      speed_out   <= '0;
      speed_valid <= 1'b0;
      stalled     <= 1'b1;
    end else begin
      speed_valid <= 1'b0;
      if (timeout_hit) begin
        div_busy  <= 1'b0;
        speed_out <= '0;
        stalled   <= 1'b1;
      end else if (div_start) begin
        div_busy    <= 1'b1;
        div_step    <= '0;
        div_divisor <= cnt;
        div_rem     <= DVD_HI;
        div_lo      <= DVD_LO;
        div_quot    <= '0;
        div_sat     <= (DVD_HI >= cnt);
      end else if (div_busy) begin
        if (div_step == 5'd26) begin
          div_busy <= 1'b0;
        end else begin
          div_rem  <= rem_next;
          div_lo   <= {div_lo[QW-2:0], 1'b0};
          div_quot <= {div_quot[QW-3:0], rem_ge};
          div_step <= div_step + 5'd1;
          if (div_step == 5'd25) begin
            speed_out   <= div_sat ? '1 : {div_quot, rem_ge};
            speed_valid <= 1'b1;
            stalled     <= 1'b0;
          end
        end
      end
    end
  end

endmodule
